// File: rtl/fma16_prod_seq_if.sv
// Operand/result handshake bundle for the fp16 FMA product stage.
// The master drives operands and out_ready; the slave (product stage) drives the results.
interface fma16_prod_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] z;
  logic        out_valid;
  logic        out_ready;
  logic        ps;
  logic [5:0]  pe;
  logic        pe_ovf;
  logic [21:0] pm;
  logic        zs;
  logic [4:0]  ze;
  logic [9:0]  zm;
  logic        special;
  logic        prod_zero;

  modport master (
    output in_valid, x, y, z, out_ready,
    input  in_ready, out_valid, ps, pe, pe_ovf, pm, zs, ze, zm, special, prod_zero
  );

  modport slave (
    input  in_valid, x, y, z, out_ready,
    output in_ready, out_valid, ps, pe, pe_ovf, pm, zs, ze, zm, special, prod_zero
  );
endinterface

// File: rtl/fma16_prod_seq.sv
// fp16 FMA front end: sequential shift-add significand product plus exponent/sign prep.
// state | meaning
// IDLE  | ready for an operand triple
// MUL   | retiring BITS_PER_CYCLE multiplier bits per cycle into the accumulator
// DONE  | results registered; out_valid follows one cycle later and holds until out_ready
module fma16_prod_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  fma16_prod_seq_if.slave    bus
);

  localparam int         ITER     = (11 + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam logic [3:0] LAST_CNT = 4'(ITER - 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [21:0] acc_q, acc_d;
  logic [21:0] xm_sh_q, xm_sh_d;
  logic [10:0] ym_sh_q, ym_sh_d;
  logic [21:0] partial;

  logic        lat_ps_q, lat_ps_d;
  logic [5:0]  lat_pe_q, lat_pe_d;
  logic        lat_ovf_q, lat_ovf_d;
  logic [15:0] lat_z_q, lat_z_d;
  logic        lat_sp_q, lat_sp_d;

  logic        out_valid_q, out_valid_d;
  logic        ps_q, ps_d;
  logic [5:0]  pe_q, pe_d;
  logic        pe_ovf_q, pe_ovf_d;
  logic [21:0] pm_q, pm_d;
  logic        zs_q, zs_d;
  logic [4:0]  ze_q, ze_d;
  logic [9:0]  zm_q, zm_d;
  logic        special_q, special_d;
  logic        prod_zero_q, prod_zero_d;
  logic        load_out;

  logic [4:0]  xe, ye, xe_eff, ye_eff;
  logic [10:0] xm, ym;
  logic [6:0]  exp_sum;
  logic        in_ps, in_ovf, in_sp, in_zero;

  assign xe      = bus.x[14:10];
  assign ye      = bus.y[14:10];
  assign xe_eff  = (xe == 5'd0) ? 5'd1 : xe;
  assign ye_eff  = (ye == 5'd0) ? 5'd1 : ye;
  assign xm      = {xe != 5'd0, bus.x[9:0]};
  assign ym      = {ye != 5'd0, bus.y[9:0]};
  // Sum spans -13..47, so 7-bit two's complement is exact; overflow means sum >= 32.
  assign exp_sum = {2'b00, xe_eff} + {2'b00, ye_eff} - 7'd15;
  assign in_ovf  = ~exp_sum[6] & exp_sum[5];
  assign in_ps   = bus.x[15] ^ bus.y[15];
  assign in_sp   = (xe == 5'h1F) || (ye == 5'h1F) || (bus.z[14:10] == 5'h1F);
  assign in_zero = (bus.x[14:0] == 15'd0) || (bus.y[14:0] == 15'd0);

  always_comb begin
    partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (ym_sh_q[j]) partial = partial + (xm_sh_q << j);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    xm_sh_d     = xm_sh_q;
    ym_sh_d     = ym_sh_q;
    lat_ps_d    = lat_ps_q;
    lat_pe_d    = lat_pe_q;
    lat_ovf_d   = lat_ovf_q;
    lat_z_d     = lat_z_q;
    lat_sp_d    = lat_sp_q;
    ps_d        = ps_q;
    pe_d        = pe_q;
    pe_ovf_d    = pe_ovf_q;
    pm_d        = pm_q;
    zs_d        = zs_q;
    ze_d        = ze_q;
    zm_d        = zm_q;
    special_d   = special_q;
    prod_zero_d = prod_zero_q;
    load_out    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          lat_ps_d  = in_ps;
          lat_pe_d  = exp_sum[5:0];
          lat_ovf_d = in_ovf;
          lat_z_d   = bus.z;
          lat_sp_d  = in_sp;
          acc_d     = '0;
          cnt_d     = '0;
          xm_sh_d   = {11'd0, xm};
          ym_sh_d   = ym;
          if (in_zero) begin
            state_d  = DONE;
            load_out = 1'b1;
          end else begin
            state_d  = MUL;
          end
        end
      end
      MUL: begin
        acc_d   = acc_q + partial;
        xm_sh_d = xm_sh_q << BITS_PER_CYCLE;
        ym_sh_d = ym_sh_q >> BITS_PER_CYCLE;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          state_d  = DONE;
          load_out = 1'b1;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Zero products skip MUL, so their fields come straight from the operand bus.
    if (load_out) begin
      if (state_q == IDLE) begin
        ps_d        = in_ps;
        pe_d        = exp_sum[5:0];
        pe_ovf_d    = in_ovf;
        pm_d        = '0;
        zs_d        = bus.z[15];
        ze_d        = bus.z[14:10];
        zm_d        = bus.z[9:0];
        special_d   = in_sp;
        prod_zero_d = 1'b1;
      end else begin
        ps_d        = lat_ps_q;
        pe_d        = lat_pe_q;
        pe_ovf_d    = lat_ovf_q;
        pm_d        = acc_d;
        zs_d        = lat_z_q[15];
        ze_d        = lat_z_q[14:10];
        zm_d        = lat_z_q[9:0];
        special_d   = lat_sp_q;
        prod_zero_d = 1'b0;
      end
    end

    out_valid_d = (state_q == DONE) && !(out_valid_q && bus.out_ready);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      xm_sh_q     <= '0;
      ym_sh_q     <= '0;
      lat_ps_q    <= 1'b0;
      lat_pe_q    <= '0;
      lat_ovf_q   <= 1'b0;
      lat_z_q     <= '0;
      lat_sp_q    <= 1'b0;
      out_valid_q <= 1'b0;
      ps_q        <= 1'b0;
      pe_q        <= '0;
      pe_ovf_q    <= 1'b0;
      pm_q        <= '0;
      zs_q        <= 1'b0;
      ze_q        <= '0;
      zm_q        <= '0;
      special_q   <= 1'b0;
      prod_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      xm_sh_q     <= xm_sh_d;
      ym_sh_q     <= ym_sh_d;
      lat_ps_q    <= lat_ps_d;
      lat_pe_q    <= lat_pe_d;
      lat_ovf_q   <= lat_ovf_d;
      lat_z_q     <= lat_z_d;
      lat_sp_q    <= lat_sp_d;
      out_valid_q <= out_valid_d;
      ps_q        <= ps_d;
      pe_q        <= pe_d;
      pe_ovf_q    <= pe_ovf_d;
      pm_q        <= pm_d;
      zs_q        <= zs_d;
      ze_q        <= ze_d;
      zm_q        <= zm_d;
      special_q   <= special_d;
      prod_zero_q <= prod_zero_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.ps        = ps_q;
  assign bus.pe        = pe_q;
  assign bus.pe_ovf    = pe_ovf_q;
  assign bus.pm        = pm_q;
  assign bus.zs        = zs_q;
  assign bus.ze        = ze_q;
  assign bus.zm        = zm_q;
  assign bus.special   = special_q;
  assign bus.prod_zero = prod_zero_q;

endmodule

// File: tb/tb_fma16_prod_seq.sv
// Bench for fma16_prod_seq: one-bit and two-bit-per-cycle instances driven in lockstep,
// each with its own scoreboard queue filled from an arithmetic reference model.
module tb_fma16_prod_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  fma16_prod_seq_if bus0 ();
  fma16_prod_seq_if bus1 ();

  fma16_prod_seq #(.BITS_PER_CYCLE(1)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  fma16_prod_seq #(.BITS_PER_CYCLE(2)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  typedef struct packed {
    logic        ov;
    logic        ir;
    logic        ps;
    logic [5:0]  pe;
    logic        pe_ovf;
    logic [21:0] pm;
    logic        zs;
    logic [4:0]  ze;
    logic [9:0]  zm;
    logic        special;
    logic        prod_zero;
  } obs_t;

  typedef struct {
    obs_t o;
    int   k;
    int   lat;
  } exp_t;

  obs_t obs0, obs1;
  assign obs0 = {bus0.out_valid, bus0.in_ready, bus0.ps, bus0.pe, bus0.pe_ovf, bus0.pm,
                 bus0.zs, bus0.ze, bus0.zm, bus0.special, bus0.prod_zero};
  assign obs1 = {bus1.out_valid, bus1.in_ready, bus1.ps, bus1.pe, bus1.pe_ovf, bus1.pm,
                 bus1.zs, bus1.ze, bus1.zm, bus1.special, bus1.prod_zero};

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   edge_cnt = 0;
  logic rnd_rdy = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int d, input logic ok,
                     input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, req);
    end
  endtask

  // Reference: significands as integers, product by plain multiplication.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic [15:0] z, input int iter, input int k);
    int   xe, ye, xm, ym, ee;
    exp_t e;
    xe = int'(x[14:10]);
    ye = int'(y[14:10]);
    xm = ((xe != 0) ? 1024 : 0) + int'(x[9:0]);
    ym = ((ye != 0) ? 1024 : 0) + int'(y[9:0]);
    ee = ((xe == 0) ? 1 : xe) + ((ye == 0) ? 1 : ye) - 15;
    e.o           = '0;
    e.o.ov        = 1'b1;
    e.o.ps        = x[15] ^ y[15];
    e.o.pe        = 6'(ee & 63);
    e.o.pe_ovf    = (ee > 31);
    e.o.pm        = 22'(xm * ym);
    e.o.zs        = z[15];
    e.o.ze        = z[14:10];
    e.o.zm        = z[9:0];
    e.o.special   = (xe == 31) || (ye == 31) || (z[14:10] == 5'h1F);
    e.o.prod_zero = (x[14:0] == 15'd0) || (y[14:0] == 15'd0);
    e.k           = k;
    e.lat         = e.o.prod_zero ? 1 : iter + 1;
    return e;
  endfunction

  function automatic logic [15:0] rnd_fp();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 7))
      0: v[14:0] = 15'd0;
      1: v[14:10] = 5'd0;
      2: v[14:10] = 5'h1F;
      default: if (v[14:10] == 5'd0) v[14:10] = 5'd1;
    endcase
    return v;
  endfunction

  task automatic set_rdy(input logic r);
    bus0.out_ready = r;
    bus1.out_ready = r;
  endtask

  task automatic tick();
    @(negedge clk);
    if (rnd_rdy) set_rdy($urandom_range(0, 3) != 0);
  endtask

  task automatic set_in(input logic v, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z);
    bus0.in_valid = v; bus0.x = x; bus0.y = y; bus0.z = z;
    bus1.in_valid = v; bus1.x = x; bus1.y = y; bus1.z = z;
  endtask

  task automatic push_exp(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    q0.push_back(model(x, y, z, 11, edge_cnt + 1));
    q1.push_back(model(x, y, z, 6, edge_cnt + 1));
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    int n;
    n = 0;
    while (n < 200 && !(bus0.in_ready && bus1.in_ready)) begin
      tick();
      n++;
    end
    chk("accept_wait", 0, bus0.in_ready && bus1.in_ready,
        64'({bus0.in_ready, bus1.in_ready}), 64'd3);
    if (bus0.in_ready && bus1.in_ready) begin
      set_in(1'b1, x, y, z);
      push_exp(x, y, z);
      tick();
      set_in(1'b0, x, y, z);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 300 && !(q0.size() == 0 && q1.size() == 0 && bus0.in_ready && bus1.in_ready)) begin
      tick();
      n++;
    end
    chk("drain", 0, q0.size() == 0 && q1.size() == 0, 64'(q0.size() + q1.size()), 64'd0);
  endtask

  // Monitor: samples just after each falling edge, independent of the stimulus.
  obs_t prv[2];
  logic pv[2];
  logic pr[2];
  obs_t mo;
  exp_t me;
  int   mlat;
  logic mhave;

  initial begin
    pv[0] = 1'b0; pv[1] = 1'b0;
    pr[0] = 1'b0; pr[1] = 1'b0;
  end

  always begin
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      mo = (d == 0) ? obs0 : obs1;
      if (!reset_n) begin
        pv[d] = 1'b0;
        pr[d] = 1'b0;
      end else begin
        if (pv[d] && !pr[d]) begin
          chk("hold", d, mo == prv[d], 64'(mo), 64'(prv[d]));
        end else if (pv[d] && pr[d]) begin
          chk("valid_fall", d, !mo.ov, 64'(mo.ov), 64'd0);
        end else if (mo.ov) begin
          mhave = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
          chk("sb_nonempty", d, mhave, 64'(mhave), 64'd1);
          if (mhave) begin
            me   = (d == 0) ? q0.pop_front() : q1.pop_front();
            mlat = edge_cnt - me.k;
            chk("result", d, mo == me.o, 64'(mo), 64'(me.o));
            chk("latency", d, mlat == me.lat, 64'(mlat), 64'(me.lat));
          end
        end
        if (mo.ov) chk("in_ready_low", d, !mo.ir, 64'(mo.ir), 64'd0);
        pv[d]  = mo.ov;
        pr[d]  = bus0.out_ready;
        prv[d] = mo;
      end
    end
  end

  obs_t rst_exp;
  int   n;

  initial begin
    set_in(1'b0, 16'd0, 16'd0, 16'd0);
    set_rdy(1'b1);
    #1 reset_n = 1'b0;
    #2;
    rst_exp    = '0;
    rst_exp.ir = 1'b1;
    chk("reset_state", 0, obs0 == rst_exp, 64'(obs0), 64'(rst_exp));
    chk("reset_state", 1, obs1 == rst_exp, 64'(obs1), 64'(rst_exp));
    tick();
    tick();
    reset_n = 1'b1;

    // Directed: basic, subnormal, zero path, exponent overflow, specials
    send(16'h3C00, 16'h4000, 16'h3C00);
    send(16'h0001, 16'h0001, 16'h1234);
    send(16'h8000, 16'h7BFF, 16'h5555);
    send(16'h7BFF, 16'h7BFF, 16'hC3A1);
    send(16'h7C00, 16'h3C00, 16'h7E00);
    send(16'h0000, 16'h7C01, 16'h0400);
    wait_idle();

    // Backpressure: new operands presented while held in DONE must be ignored
    set_rdy(1'b0);
    send(16'h3C00, 16'h4000, 16'h3C00);
    n = 0;
    while (n < 40 && !(bus0.out_valid && bus1.out_valid)) begin
      tick();
      n++;
    end
    chk("bp_done", 0, bus0.out_valid && bus1.out_valid,
        64'({bus0.out_valid, bus1.out_valid}), 64'd3);
    set_in(1'b1, 16'h4248, 16'h3555, 16'hABCD);
    repeat (5) tick();
    chk("bp_in_ready", 0, !bus0.in_ready, 64'(bus0.in_ready), 64'd0);
    chk("bp_in_ready", 1, !bus1.in_ready, 64'(bus1.in_ready), 64'd0);
    set_rdy(1'b1);
    tick();
    chk("b2b_ready", 0, bus0.in_ready && bus1.in_ready,
        64'({bus0.in_ready, bus1.in_ready}), 64'd3);
    push_exp(16'h4248, 16'h3555, 16'hABCD);
    tick();
    set_in(1'b0, 16'd0, 16'd0, 16'd0);
    wait_idle();

    // Reset in the middle of MUL abandons the operation
    send(16'h3C00, 16'h4000, 16'h3C00);
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk("rst_valid", 0, !bus0.out_valid, 64'(bus0.out_valid), 64'd0);
    chk("rst_valid", 1, !bus1.out_valid, 64'(bus1.out_valid), 64'd0);
    chk("rst_pm", 0, bus0.pm == 22'd0, 64'(bus0.pm), 64'd0);
    chk("rst_pm", 1, bus1.pm == 22'd0, 64'(bus1.pm), 64'd0);
    chk("rst_ready", 0, bus0.in_ready, 64'(bus0.in_ready), 64'd1);
    chk("rst_ready", 1, bus1.in_ready, 64'(bus1.in_ready), 64'd1);
    q0.delete();
    q1.delete();
    tick();
    reset_n = 1'b1;
    send(16'h3C00, 16'h4000, 16'h3C00);
    wait_idle();

    // Random operands under random backpressure
    rnd_rdy = 1'b1;
    repeat (40) send(rnd_fp(), rnd_fp(), rnd_fp());
    rnd_rdy = 1'b0;
    set_rdy(1'b1);
    wait_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
